// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU VRAM arbiter: FSM states, requester ids
// and the palette window that is never written through the external VRAM port.
package ppu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    localparam int NUM_REQ = 3;
    localparam int REQ_SPR = 0;
    localparam int REQ_BG  = 1;
    localparam int REQ_RI  = 2;

    localparam logic [13:0] PALETTE_BASE = 14'h3F00;

    // Palette writes are served outside this block, so only name-table/pattern writes strobe.
    function automatic logic is_vram_write(input logic wr, input logic [13:0] addr);
        return wr && (addr < PALETTE_BASE);
    endfunction

endpackage

// File: rtl/ppu_vram_arb_prio.sv
// Combinational winner select for the VRAM arbiter: fixed priority spr > bg > ri,
// overridden in favour of a pending ri request when the starve flag is raised.
module ppu_vram_arb_prio
    import ppu_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_starve,
    output logic [NUM_REQ-1:0] o_win
);

    always_comb begin
        // NOTE: default assigned first so every path drives o_win and no latch is inferred.
        o_win = '0;
        if (i_starve && i_req[REQ_RI]) begin
            o_win[REQ_RI] = 1'b1;
        end else if (i_req[REQ_SPR]) begin
            o_win[REQ_SPR] = 1'b1;
        end else if (i_req[REQ_BG]) begin
            o_win[REQ_BG] = 1'b1;
        end else if (i_req[REQ_RI]) begin
            o_win[REQ_RI] = 1'b1;
        end
    end

endmodule

// File: rtl/ppu_vram_arb.sv
// VRAM port arbiter/sequencer: sprite, background and register-interface accesses in
// two-cycle ADDR/DATA slots. Optional RI starvation guard: PPU_VRAM_ARB_STARVE_GUARD_EN.
module ppu_vram_arb
    import ppu_pkg::*;
#(
    parameter int STARVE_MAX = 8
)
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        spr_req_in,
    input  logic [13:0] spr_a_in,
    output logic        spr_gnt_out,
    output logic        spr_vld_out,
    input  logic        bg_req_in,
    input  logic [13:0] bg_a_in,
    output logic        bg_gnt_out,
    output logic        bg_vld_out,
    input  logic        ri_req_in,
    input  logic        ri_wr_in,
    input  logic [13:0] ri_a_in,
    input  logic [7:0]  ri_d_in,
    output logic        ri_gnt_out,
    output logic        ri_vld_out,
    output logic [7:0]  rd_d_out,
    input  logic [7:0]  vram_d_in,
    output logic [13:0] vram_a_out,
    output logic [7:0]  vram_d_out,
    output logic        vram_wr_out,
    output logic        busy_out
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("ppu_vram_arb: STARVE_MAX must be in 1..15");
    end

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_win;
    logic [NUM_REQ-1:0] r_owner;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_vld;
    logic               w_arb_en;
    logic               w_take;
    logic               w_starve;
    logic               r_wr;
    logic               r_wr_strobe;
    logic [13:0]        r_addr;
    logic [7:0]         r_wdata;
    logic [7:0]         r_rd_d;

    assign w_req    = {ri_req_in, bg_req_in, spr_req_in};
    assign w_arb_en = (r_state == ARB_IDLE) || (r_state == ARB_DATA);
    assign w_take   = w_arb_en && (|w_win);

`ifdef PPU_VRAM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] r_starve_cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_starve_cnt <= 4'd0;
        end else if (!ri_req_in || (w_take && w_win[REQ_RI])) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != 4'hF) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    assign w_starve = (r_starve_cnt >= STARVE_LIM);
`else
    assign w_starve = 1'b0;
`endif

    ppu_vram_arb_prio u_prio (
        .i_req    (w_req),
        .i_starve (w_starve),
        .o_win    (w_win)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ARB_IDLE: if (|w_req) w_state_nxt = ARB_ADDR;
            ARB_ADDR: w_state_nxt = ARB_DATA;
            ARB_DATA: w_state_nxt = (|w_req) ? ARB_ADDR : ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
    end

    // Grant, write strobe and valid are single-cycle pulses: cleared every edge unless re-set.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_gnt       <= '0;
            r_vld       <= '0;
            r_owner     <= '0;
            r_wr        <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_addr      <= 14'd0;
            r_wdata     <= 8'd0;
            r_rd_d      <= 8'd0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            r_gnt       <= '0;
            r_vld       <= '0;
            r_wr_strobe <= 1'b0;
            if (w_take) begin
                r_gnt   <= w_win;
                r_owner <= w_win;
                r_wr    <= w_win[REQ_RI] && ri_wr_in;
                if (w_win[REQ_SPR]) begin
                    r_addr <= spr_a_in;
                end else if (w_win[REQ_BG]) begin
                    r_addr <= bg_a_in;
                end else begin
                    r_addr <= ri_a_in;
                end
                if (w_win[REQ_RI] && ri_wr_in) begin
                    r_wdata     <= ri_d_in;
                    r_wr_strobe <= is_vram_write(ri_wr_in, ri_a_in);
                end
            end
            if (r_state == ARB_DATA) begin
                r_vld <= r_owner;
                if (!r_wr) begin
                    r_rd_d <= vram_d_in;
                end
            end
        end
    end

    assign spr_gnt_out = r_gnt[REQ_SPR];
    assign bg_gnt_out  = r_gnt[REQ_BG];
    assign ri_gnt_out  = r_gnt[REQ_RI];
    assign spr_vld_out = r_vld[REQ_SPR];
    assign bg_vld_out  = r_vld[REQ_BG];
    assign ri_vld_out  = r_vld[REQ_RI];
    assign rd_d_out    = r_rd_d;
    assign vram_a_out  = r_addr;
    assign vram_d_out  = r_wdata;
    assign vram_wr_out = r_wr_strobe;
    assign busy_out    = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_ppu_vram_arb.sv
// Self-checking bench for ppu_vram_arb: directed scenarios plus random traffic against a
// slot-timeline reference model. Honours PPU_VRAM_ARB_STARVE_GUARD_EN when defined.
module tb_ppu_vram_arb;

    localparam int NC         = 2048;
    localparam int STARVE_MAX = 8;
`ifdef PPU_VRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        spr_req_in, bg_req_in, ri_req_in, ri_wr_in;
    logic [13:0] spr_a_in, bg_a_in, ri_a_in;
    logic [7:0]  ri_d_in, vram_d_in;
    logic        spr_gnt_out, spr_vld_out, bg_gnt_out, bg_vld_out, ri_gnt_out, ri_vld_out;
    logic [7:0]  rd_d_out, vram_d_out;
    logic [13:0] vram_a_out;
    logic        vram_wr_out, busy_out;

    ppu_vram_arb #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .spr_req_in(spr_req_in), .spr_a_in(spr_a_in), .spr_gnt_out(spr_gnt_out), .spr_vld_out(spr_vld_out),
        .bg_req_in(bg_req_in), .bg_a_in(bg_a_in), .bg_gnt_out(bg_gnt_out), .bg_vld_out(bg_vld_out),
        .ri_req_in(ri_req_in), .ri_wr_in(ri_wr_in), .ri_a_in(ri_a_in), .ri_d_in(ri_d_in),
        .ri_gnt_out(ri_gnt_out), .ri_vld_out(ri_vld_out), .rd_d_out(rd_d_out),
        .vram_d_in(vram_d_in), .vram_a_out(vram_a_out), .vram_d_out(vram_d_out),
        .vram_wr_out(vram_wr_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous VRAM with 1-cycle read latency; unwritten locations return a fixed hash.
    function automatic logic [7:0] init_val(input logic [13:0] a);
        return a[7:0] ^ {2'b10, a[13:8]};
    endfunction

    logic [7:0] mem [16384];
    bit         written [16384];
    logic [7:0] ref_mem [16384];

    always @(posedge clk_in) begin
        if (vram_wr_out) begin
            mem[vram_a_out]     <= vram_d_out;
            written[vram_a_out] <= 1'b1;
        end
        vram_d_in <= written[vram_a_out] ? mem[vram_a_out] : init_val(vram_a_out);
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Requester agents (index 0 spr, 1 bg, 2 ri)
    bit          a_req [3];
    logic [13:0] a_addr [3];
    bit          just_drop [3];
    int          pct [3];
    logic [7:0]  ri_d;
    bit          ri_wr;

    // Reference model: expected outputs per cycle, plus held values
    bit [2:0]    e_gnt [NC];
    bit [2:0]    e_vld [NC];
    bit          e_wr [NC], e_busy [NC], e_a_set [NC], e_rd_set [NC], e_wd_set [NC];
    logic [13:0] e_a [NC];
    logic [7:0]  e_rd [NC], e_wd [NC];
    logic [13:0] cur_a  = 14'd0;
    logic [7:0]  cur_rd = 8'd0;
    logic [7:0]  cur_wd = 8'd0;
    int          next_arb = 0;
    int          starve   = 0;

    // Observed DUT history, for directed checks that refer to specific cycles
    bit [2:0]    h_gnt [NC];
    bit [2:0]    h_vld [NC];
    bit          h_wr [NC];
    logic [13:0] h_a [NC];
    logic [7:0]  h_rd [NC], h_wd [NC];

    function automatic logic [13:0] rand_addr();
        if ($urandom_range(7) == 0) return 14'h3F00 | 14'($urandom_range(255));
        return 14'($urandom_range(16383));
    endfunction

    task automatic request(input int i, input logic [13:0] a, input logic [7:0] d, input bit wr);
        a_req[i]  = 1'b1;
        a_addr[i] = a;
        if (i == 2) begin
            ri_d  = d;
            ri_wr = wr;
        end
    endtask

    task automatic drive();
        spr_req_in = a_req[0]; spr_a_in = a_addr[0];
        bg_req_in  = a_req[1]; bg_a_in  = a_addr[1];
        ri_req_in  = a_req[2]; ri_a_in  = a_addr[2];
        ri_wr_in   = ri_wr;    ri_d_in  = ri_d;
    endtask

    // Slot rules: an access may start at an edge no earlier than 2 cycles after the previous
    // start; the grant shows one cycle later, the valid three cycles later.
    task automatic model_edge();
        int win;
        int g;
        win = -1;
        if (cyc >= next_arb) begin
            if (GUARD && a_req[2] && starve >= STARVE_MAX) win = 2;
            else if (a_req[0]) win = 0;
            else if (a_req[1]) win = 1;
            else if (a_req[2]) win = 2;
        end
        if (!a_req[2] || win == 2) starve = 0;
        else if (starve < 15) starve++;
        if (win >= 0) begin
            g = cyc + 1;
            next_arb = cyc + 2;
            e_gnt[g][win] = 1'b1;
            e_busy[g] = 1'b1;
            e_busy[g + 1] = 1'b1;
            e_a_set[g] = 1'b1;
            e_a[g] = a_addr[win];
            e_vld[cyc + 3][win] = 1'b1;
            if (win == 2 && ri_wr) begin
                e_wd_set[g] = 1'b1;
                e_wd[g] = ri_d;
                if (a_addr[2] < 14'h3F00) begin
                    e_wr[g] = 1'b1;
                    ref_mem[a_addr[2]] = ri_d;
                end
            end else begin
                e_rd_set[cyc + 3] = 1'b1;
                e_rd[cyc + 3] = ref_mem[a_addr[win]];
            end
        end
    endtask

    task automatic model_reset();
        for (int k = cyc + 1; k < NC; k++) begin
            e_gnt[k] = '0; e_vld[k] = '0; e_wr[k] = 1'b0; e_busy[k] = 1'b0;
            e_a_set[k] = 1'b0; e_rd_set[k] = 1'b0; e_wd_set[k] = 1'b0;
        end
        e_a_set[cyc + 1]  = 1'b1; e_a[cyc + 1]  = 14'd0;
        e_rd_set[cyc + 1] = 1'b1; e_rd[cyc + 1] = 8'd0;
        e_wd_set[cyc + 1] = 1'b1; e_wd[cyc + 1] = 8'd0;
        next_arb = 0;
        starve   = 0;
    endtask

    task automatic step();
        @(negedge clk_in);
        cyc++;
        if (e_a_set[cyc])  cur_a  = e_a[cyc];
        if (e_rd_set[cyc]) cur_rd = e_rd[cyc];
        if (e_wd_set[cyc]) cur_wd = e_wd[cyc];
        h_gnt[cyc] = {ri_gnt_out, bg_gnt_out, spr_gnt_out};
        h_vld[cyc] = {ri_vld_out, bg_vld_out, spr_vld_out};
        h_wr[cyc]  = vram_wr_out;
        h_a[cyc]   = vram_a_out;
        h_rd[cyc]  = rd_d_out;
        h_wd[cyc]  = vram_d_out;
        check("gnt", 32'(h_gnt[cyc]), 32'(e_gnt[cyc]));
        check("vld", 32'(h_vld[cyc]), 32'(e_vld[cyc]));
        check("vram_wr", 32'(vram_wr_out), 32'(e_wr[cyc]));
        check("busy", 32'(busy_out), 32'(e_busy[cyc]));
        check("vram_a", 32'(vram_a_out), 32'(cur_a));
        check("rd_d", 32'(rd_d_out), 32'(cur_rd));
        check("vram_d", 32'(vram_d_out), 32'(cur_wd));
        for (int i = 0; i < 3; i++) begin
            just_drop[i] = 1'b0;
            if (a_req[i] && e_gnt[cyc - 1][i]) begin
                a_req[i] = 1'b0;
                just_drop[i] = 1'b1;
            end else if (!a_req[i] && int'($urandom_range(99)) < pct[i]) begin
                request(i, rand_addr(), 8'($urandom_range(255)), bit'($urandom_range(1)));
            end
        end
        drive();
        model_edge();
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 32'({spr_gnt_out, spr_vld_out, bg_gnt_out, bg_vld_out,
                                  ri_gnt_out, ri_vld_out, vram_wr_out, busy_out}), 32'd0);
        check({tag, "_a"}, 32'(vram_a_out), 32'd0);
        check({tag, "_d"}, 32'({vram_d_out, rd_d_out}), 32'd0);
    endtask

    initial begin
        int s;
        int r;
        int found;
        int any;
        logic [7:0] old;

        for (int k = 0; k < 16384; k++) ref_mem[k] = init_val(14'(k));
        for (int i = 0; i < 3; i++) begin
            a_req[i] = 1'b0; a_addr[i] = 14'd0; pct[i] = 0;
        end
        ri_d = 8'd0; ri_wr = 1'b0;
        drive();
        rst_n_in = 1'b1;
        #3 rst_n_in = 1'b0;
        #4 check_all_zero("reset");
        repeat (2) @(posedge clk_in);
        @(negedge clk_in) rst_n_in = 1'b1;

        // RI write to name table, then the same write into the palette window
        request(2, 14'h23C0, 8'hA7, 1'b1); s = cyc + 1; step_n(6);
        check("wr_strobe", 32'(h_wr[s + 1]), 32'd1);
        check("wr_data", 32'(h_wd[s + 1]), 32'hA7);
        check("wr_one_cycle", 32'(h_wr[s + 2]), 32'd0);
        check("wr_vld", 32'(h_vld[s + 3]), 32'b100);
        request(2, 14'h3F05, 8'hA7, 1'b1); s = cyc + 1; step_n(6);
        any = 0;
        for (int k = s; k < s + 6; k++) any |= int'(h_wr[k]);
        check("pal_no_wr", 32'(any), 32'd0);
        check("pal_vld", 32'(h_vld[s + 3]), 32'b100);

        // Single background read of 8'h5A placed by an RI write
        request(2, 14'h2000, 8'h5A, 1'b1); step_n(6);
        request(1, 14'h2000, 8'h00, 1'b0); s = cyc + 1; step_n(6);
        check("bg_gnt", 32'(h_gnt[s + 1]), 32'b010);
        check("bg_addr", 32'(h_a[s + 1]), 32'h2000);
        check("bg_vld", 32'(h_vld[s + 3]), 32'b010);
        check("bg_data", 32'(h_rd[s + 3]), 32'h5A);

        // All three at once: spr, bg, ri in slots two cycles apart
        request(0, 14'h0100, 8'h00, 1'b0);
        request(1, 14'h2000, 8'h00, 1'b0);
        request(2, 14'h23C0, 8'h00, 1'b0);
        s = cyc + 1; step_n(10);
        check("all_gnt_spr", 32'(h_gnt[s + 1]), 32'b001);
        check("all_gnt_bg", 32'(h_gnt[s + 3]), 32'b010);
        check("all_gnt_ri", 32'(h_gnt[s + 5]), 32'b100);
        check("all_vld_spr", 32'(h_vld[s + 3]), 32'b001);
        check("all_vld_bg", 32'(h_vld[s + 5]), 32'b010);
        check("all_vld_ri", 32'(h_vld[s + 7]), 32'b100);
        check("all_ri_data", 32'(h_rd[s + 7]), 32'hA7);

        // Continuous spr/bg traffic against a pending RI read
        pct[0] = 100; pct[1] = 100;
        step_n(8);
        request(2, 14'h0123, 8'h00, 1'b0); r = cyc + 1; step_n(24);
        found = -1;
        for (int k = r; k < r + 24; k++) if (found < 0 && h_gnt[k][2]) found = k;
        if (GUARD) check("starve_ri_in_bound", 32'(found >= 0 && found - r <= 10), 32'd1);
        else       check("starve_ri_none", 32'(found), 32'hFFFF_FFFF);
        pct[0] = 0; pct[1] = 0;
        step_n(14);

        // Reset pulsed during the ADDR cycle of an RI write
        old = ref_mem[14'h23C0];
        request(2, 14'h23C0, 8'h3C, 1'b1); s = cyc + 1; step_n(2);
        check("rst_pre_wr", 32'(h_wr[s + 1]), 32'd1);
        rst_n_in = 1'b0;
        a_req[2] = 1'b0;
        drive();
        #1 check_all_zero("rst_mid");
        model_reset();
        ref_mem[14'h23C0] = old;
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        step_n(8);
        any = 0;
        for (int k = s + 2; k < s + 10; k++) any |= int'(h_vld[k]) | int'(h_wr[k]);
        check("rst_no_vld_wr", 32'(any), 32'd0);

        // Random mixed traffic
        pct[0] = 30; pct[1] = 30; pct[2] = 30;
        step_n(800);
        pct[0] = 0; pct[1] = 0; pct[2] = 0;
        step_n(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppu_vram_arb.md
# ppu_vram_arb

VRAM bus arbiter and access sequencer for the PPU. Shares the single 14-bit external video-memory port between the sprite fetcher, the background fetcher and the CPU register interface ($2007 reads and writes). Each access runs a fixed address/data slot sequence, and the read data is returned with a per-requester valid pulse. The block sits between the three PPU requesters and the vram_a/d/wr pins, replacing the plain sprite/background address mux.

## Interface
- STARVE_MAX, 8: number of consecutive losing cycles after which a pending RI request overrides all priority (range 1–15).
- clk_in  in  1  50 MHz system clock.
- rst_n_in  in  1  reset, asynchronous, active-low.
- spr_req_in  in  1  sprite fetch request.
- spr_a_in  in  14  sprite fetch address.
- spr_gnt_out  out  1  sprite grant pulse.
- spr_vld_out  out  1  sprite read data valid pulse.
- bg_req_in  in  1  background fetch request.
- bg_a_in  in  14  background fetch address.
- bg_gnt_out  out  1  background grant pulse.
- bg_vld_out  out  1  background read data valid pulse.
- ri_req_in  in  1  register interface request.
- ri_wr_in  in  1  RI access is a write (1) or read (0).
- ri_a_in  in  14  RI address.
- ri_d_in  in  8  RI write data.
- ri_gnt_out  out  1  RI grant pulse.
- ri_vld_out  out  1  RI completion pulse (read data valid, or write done).
- rd_d_out  out  8  shared read data, qualified by the *_vld_out pulses.
- vram_d_in  in  8  VRAM read data (synchronous RAM, 1-cycle latency).
- vram_a_out  out  14  VRAM address.
- vram_d_out  out  8  VRAM write data.
- vram_wr_out  out  1  VRAM write strobe.
- busy_out  out  1  high while the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate at each edge. Any request → ADDR; otherwise stay in IDLE.
  - ADDR → DATA, unconditionally.
  - DATA: arbitrate again. Any request → ADDR; none → IDLE. This gives back-to-back slots, one access every 2 cycles.
- Arbitration happens at the edge leaving IDLE or DATA.
  - Fixed priority: spr > bg > ri.
  - With the starvation guard enabled, ri wins when starve_cnt ≥ STARVE_MAX.
- At the winning edge, the arbiter captures the winner id, address, write flag and write data.
  - Requesters hold req/addr/data stable until they see gnt.
  - A requester drops req on the edge that ends its gnt cycle.
  - A req dropped before gnt is ignored and never granted.
- ADDR cycle:
  - gnt_out of the owner is high (registered, one cycle).
  - vram_a_out = captured address.
  - vram_wr_out = 1 only for an RI write with address < 14'h3F00.
  - vram_d_out = captured data.
- DATA cycle: vram_wr_out = 0. vram_d_in is valid and is registered into rd_d_out at the end of the cycle.
- Cycle after DATA:
  - The owner's vld_out pulses high for one cycle.
  - rd_d_out holds its value until the next read capture.
  - RI writes pulse ri_vld_out but do not update rd_d_out.
- Palette region: RI writes to 14'h3F00–14'h3FFF are not forwarded (vram_wr_out stays 0). The slot and vld still occur, because the palette RAM is handled outside this block.
- vram_a_out holds the last address when the FSM is IDLE. vram_d_out holds the last write data.
- starve_cnt (4 bits):
  - increments each cycle ri_req_in is high and ri is not granted;
  - saturates at 15;
  - clears on ri grant or when ri_req_in is low.

## Timing
- Reset values, applied asynchronously while rst_n_in = 0:
  - All gnt/vld outputs, vram_wr_out and busy_out are 0.
  - vram_a_out, vram_d_out and rd_d_out are 0.
  - FSM is IDLE; starve_cnt is 0.
- Reset mid-access abandons the slot. No vld is issued and no write strobe is issued after release.
- Latency:
  - req sampled at edge E0 → gnt in cycle E0..E1 → vld in cycle E2..E3.
  - 3 cycles from arbitration edge to vld.
- Simultaneous requests: exactly one gnt per slot. Losers stay pending and are re-arbitrated in the DATA cycle of the current slot.
- A vld pulse and the next slot's gnt pulse may be high in the same cycle, possibly to the same requester.

## Configuration
- PPU_VRAM_ARB_STARVE_GUARD_EN:
  - Defined: starve_cnt and the STARVE_MAX override are built.
  - Undefined: pure fixed priority. starve_cnt is not built and STARVE_MAX is unused. RI can be starved indefinitely by continuous spr/bg traffic.

## Structure
- ppu_pkg holds:
  - FSM state constants: ARB_IDLE, ARB_ADDR, ARB_DATA.
  - Requester ids: REQ_SPR, REQ_BG, REQ_RI.
  - PALETTE_BASE = 14'h3F00.
- One sub-module, ppu_vram_arb_prio: combinational winner select from the three reqs plus the starve flag; outputs a one-hot winner.

## Test plan
- Single bg read: bg_a_in = 14'h2000, and VRAM returns 8'h5A in DATA. Required: bg_gnt_out in cycle 1, vram_a_out = 14'h2000 in cycle 1, bg_vld_out with rd_d_out = 8'h5A in cycle 3.
- All three requesting at once: grant order spr, bg, ri, in slots 2 cycles apart. vld order matches the grant order.
- RI write 8'hA7 to 14'h23C0: one-cycle vram_wr_out with vram_d_out = 8'hA7. The same write to 14'h3F05 gives vram_wr_out = 0 throughout, and ri_vld_out still pulses.
- Macro defined, STARVE_MAX = 8, spr and bg requesting continuously, RI requesting: ri is granted once starve_cnt has reached 8 (at most 10 cycles after ri_req_in rises). Macro undefined: ri is never granted while spr and bg keep requesting.
- rst_n_in pulsed low during the ADDR cycle of an RI write: vram_wr_out drops to 0 immediately, every output reads 0, and no vld occurs after release.
